// File: rtl/act_bitplane_serializer_if.sv
// Handshake bundle between an activation producer, the bit-plane serializer and the PE.
// master = producer/consumer side, slave = serializer side.
interface act_bitplane_serializer_if #(
    parameter int peDataInWidth = 1024,
    parameter int actBits       = 4,
    parameter int planeIdxWidth = (actBits > 1) ? $clog2(actBits) : 1
);
    logic                               in_valid;
    logic                               in_ready;
    logic [peDataInWidth*actBits-1:0]   in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [peDataInWidth-1:0]           out_data;
    logic [planeIdxWidth-1:0]           out_plane;
    logic                               out_first;
    logic                               out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_plane, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_plane, out_first, out_last
    );
endinterface

// File: rtl/act_bitplane_serializer.sv
// Splits one activation vector into actBits bit-planes, one plane per cycle, for the PE.
// Define ACT_BITPLANE_MSB_FIRST_EN to emit planes MSB first (default is LSB first).
module act_bitplane_serializer #(
    parameter int nSaRows       = 256,
    parameter int nRowSaInPE    = 4,
    parameter int actBits       = 4,
    parameter int peDataInWidth = nSaRows * nRowSaInPE,
    parameter int planeIdxWidth = (actBits > 1) ? $clog2(actBits) : 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    act_bitplane_serializer_if.slave   bus
);

    localparam int vec_width = peDataInWidth * actBits;
    localparam logic [planeIdxWidth-1:0] last_cnt = planeIdxWidth'(actBits - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [planeIdxWidth-1:0]   cnt;
    logic [planeIdxWidth-1:0]   cnt_next;
    logic [vec_width-1:0]       act_reg;
    logic [vec_width-1:0]       act_next;
    logic                       at_last;
    logic                       in_ready;
    logic                       out_valid;
    logic [planeIdxWidth-1:0]   plane_idx;
    logic [peDataInWidth-1:0]   plane_bits;

    // nrst is an active-high synchronous reset despite its name
    always_ff @(posedge clk) begin
        if (nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            act_reg <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            act_reg <= act_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        act_next   = act_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        at_last    = (cnt == last_cnt);

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    act_next   = bus.in_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                out_valid = 1'b1;
                // Accepting into the last-plane slot keeps the PE fed without a bubble
                in_ready  = bus.out_ready && at_last;
                if (bus.out_ready) begin
                    if (!at_last) begin
                        cnt_next = cnt + planeIdxWidth'(1);
                    end else if (bus.in_valid) begin
                        act_next = bus.in_data;
                        cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
`ifdef ACT_BITPLANE_MSB_FIRST_EN
        plane_idx = last_cnt - cnt;
`else
        plane_idx = cnt;
`endif
    end

    always_comb begin
        plane_bits = '0;
        for (int e = 0; e < peDataInWidth; e++) begin
            plane_bits[e] = act_reg[e*actBits + int'(plane_idx)];
        end
    end

    // Outputs are forced to zero while no plane is presented
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? plane_bits : '0;
    assign bus.out_plane = out_valid ? plane_idx : '0;
    assign bus.out_first = out_valid && (cnt == '0);
    assign bus.out_last  = out_valid && at_last;

endmodule

// File: tb/tb_act_bitplane_serializer.sv
// Scoreboard bench for act_bitplane_serializer; honours ACT_BITPLANE_MSB_FIRST_EN when defined.
module tb_act_bitplane_serializer;

    localparam int AB  = 4;
    localparam int PW  = 256 * 4;
    localparam int VW  = PW * AB;
    localparam int PIW = 2;

    typedef struct {
        logic [PW-1:0]  data;
        logic [PIW-1:0] plane;
        logic           first;
        logic           last;
    } plane_t;

    logic clk;
    logic nrst;

    act_bitplane_serializer_if #(.peDataInWidth(PW), .actBits(AB), .planeIdxWidth(PIW)) bus();

    act_bitplane_serializer #(
        .nSaRows(256), .nRowSaInPE(4), .actBits(AB)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    plane_t          sb[$];
    int              tests_run;
    int              tests_failed;

    logic            obs_in_ready;
    logic            obs_out_valid;
    logic [PW-1:0]   obs_data;
    logic [PIW-1:0]  obs_plane;
    logic            obs_first;
    logic            obs_last;
    logic            exp_in_ready;
    logic            exp_out_valid;
    logic            has_exp;
    plane_t          exp_item;

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_vector(input logic [VW-1:0] v);
        plane_t it;
        int p;
        for (int k = 0; k < AB; k++) begin
`ifdef ACT_BITPLANE_MSB_FIRST_EN
            p = AB - 1 - k;
`else
            p = k;
`endif
            for (int e = 0; e < PW; e++) it.data[e] = v[e*AB + p];
            it.plane = PIW'(p);
            it.first = (k == 0);
            it.last  = (k == AB - 1);
            sb.push_back(it);
        end
    endtask

    // Drives one cycle, samples outputs 1ns later, and advances the scoreboard
    task automatic run_cycle(input logic iv, input logic [VW-1:0] d, input logic ordy, input logic rst);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        nrst          = rst;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        obs_data      = bus.out_data;
        obs_plane     = bus.out_plane;
        obs_first     = bus.out_first;
        obs_last      = bus.out_last;
        exp_out_valid = (sb.size() != 0);
        exp_in_ready  = (sb.size() == 0) || (ordy && sb.size() == 1);
        has_exp       = (sb.size() != 0);
        if (has_exp) exp_item = sb[0];
        if (rst) begin
            sb.delete();
        end else begin
            if (exp_out_valid && ordy) void'(sb.pop_front());
            if (iv && exp_in_ready) push_vector(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        nrst          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_handshake c%0d: out_valid=%b in_ready=%b, want 0/1", c, obs_out_valid, obs_in_ready);
            end
            tests_run++;
            if (obs_data !== '0 || obs_plane !== '0 || obs_first !== 1'b0 || obs_last !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs c%0d: data_lo=%h plane=%0d first=%b last=%b, want all 0",
                         c, obs_data[63:0], obs_plane, obs_first, obs_last);
            end
        end
    endtask

    task automatic test_single_vector();
        logic [VW-1:0]  v;
        logic [AB-1:0]  bit0_seq;
        logic [PIW-1:0] want_plane;
        v = '0;
        v[3:0] = 4'b1011;
`ifdef ACT_BITPLANE_MSB_FIRST_EN
        bit0_seq = 4'b1101;
`else
        bit0_seq = 4'b1011;
`endif
        run_cycle(1'b1, v, 1'b1, 1'b0);
        tests_run++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_capture: in_ready=%b out_valid=%b, want 1/0", obs_in_ready, obs_out_valid);
        end
        for (int k = 0; k < AB; k++) begin
`ifdef ACT_BITPLANE_MSB_FIRST_EN
            want_plane = PIW'(AB - 1 - k);
`else
            want_plane = PIW'(k);
`endif
            run_cycle(1'b0, rand_vec(), 1'b1, 1'b0);
            tests_run++;
            if (obs_out_valid !== 1'b1 || obs_data[0] !== bit0_seq[k] || obs_plane !== want_plane) begin
                tests_failed++;
                $display("[TB] FAIL single_plane k%0d: valid=%b bit0=%b plane=%0d, want 1/%b/%0d",
                         k, obs_out_valid, obs_data[0], obs_plane, bit0_seq[k], want_plane);
            end
            tests_run++;
            if (obs_data[PW-1:1] !== '0 || obs_first !== (k == 0) || obs_last !== (k == AB - 1)) begin
                tests_failed++;
                $display("[TB] FAIL single_flags k%0d: upper_nonzero=%b first=%b last=%b",
                         k, |obs_data[PW-1:1], obs_first, obs_last);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_end: out_valid=%b in_ready=%b, want 0/1", obs_out_valid, obs_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] vecs[4];
        int idx;
        logic iv;
        for (int i = 0; i < 4; i++) vecs[i] = rand_vec();
        idx = 0;
        for (int c = 0; c < 18; c++) begin
            iv = (idx < 4);
            run_cycle(iv, iv ? vecs[idx] : '0, 1'b1, 1'b0);
            tests_run++;
            if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid) begin
                tests_failed++;
                $display("[TB] FAIL b2b_handshake c%0d: in_ready=%b out_valid=%b, want %b/%b",
                         c, obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid);
            end
            if (has_exp) begin
                tests_run++;
                if (obs_data !== exp_item.data || obs_plane !== exp_item.plane ||
                    obs_first !== exp_item.first || obs_last !== exp_item.last) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_plane c%0d: data_lo=%h plane=%0d f=%b l=%b, want %h/%0d/%b/%b",
                             c, obs_data[63:0], obs_plane, obs_first, obs_last,
                             exp_item.data[63:0], exp_item.plane, exp_item.first, exp_item.last);
                end
            end
            if (iv && exp_in_ready) idx++;
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v;
        v = rand_vec();
        run_cycle(1'b1, v, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            // cycles 1..3 stall on plane index 1 while a new vector is offered
            if (c >= 1 && c <= 3) run_cycle(1'b1, rand_vec(), 1'b0, 1'b0);
            else                  run_cycle(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid) begin
                tests_failed++;
                $display("[TB] FAIL bp_handshake c%0d: in_ready=%b out_valid=%b, want %b/%b",
                         c, obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid);
            end
            if (has_exp) begin
                tests_run++;
                if (obs_data !== exp_item.data || obs_plane !== exp_item.plane ||
                    obs_first !== exp_item.first || obs_last !== exp_item.last) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_plane c%0d: data_lo=%h plane=%0d f=%b l=%b, want %h/%0d/%b/%b",
                             c, obs_data[63:0], obs_plane, obs_first, obs_last,
                             exp_item.data[63:0], exp_item.plane, exp_item.first, exp_item.last);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [VW-1:0] v;
        v = rand_vec();
        run_cycle(1'b1, v, 1'b1, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        tests_run++;
        if (!has_exp || obs_plane !== exp_item.plane || obs_data !== exp_item.data) begin
            tests_failed++;
            $display("[TB] FAIL mreset_p2: plane=%0d data_lo=%h, want plane %0d", obs_plane, obs_data[63:0], exp_item.plane);
        end
        run_cycle(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (obs_out_valid !== 1'b0 || obs_plane !== '0 || obs_data !== '0 || obs_in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mreset_after: valid=%b plane=%0d data_lo=%h in_ready=%b, want 0/0/0/1",
                     obs_out_valid, obs_plane, obs_data[63:0], obs_in_ready);
        end
        v = rand_vec();
        run_cycle(1'b1, v, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (obs_out_valid !== exp_out_valid) begin
                tests_failed++;
                $display("[TB] FAIL mreset_restart_valid c%0d: %b, want %b", c, obs_out_valid, exp_out_valid);
            end
            if (has_exp) begin
                tests_run++;
                if (obs_data !== exp_item.data || obs_plane !== exp_item.plane ||
                    obs_first !== exp_item.first || obs_last !== exp_item.last) begin
                    tests_failed++;
                    $display("[TB] FAIL mreset_restart_plane c%0d: plane=%0d f=%b l=%b, want %0d/%b/%b",
                             c, obs_plane, obs_first, obs_last, exp_item.plane, exp_item.first, exp_item.last);
                end
            end
        end
    endtask

    task automatic test_random();
        logic iv;
        logic ordy;
        for (int c = 0; c < 220; c++) begin
            iv   = (c < 200) && ($urandom_range(0, 9) < 7);
            ordy = (c >= 200) || ($urandom_range(0, 9) < 7);
            run_cycle(iv, rand_vec(), ordy, 1'b0);
            tests_run++;
            if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid) begin
                tests_failed++;
                $display("[TB] FAIL rand_handshake c%0d: in_ready=%b out_valid=%b, want %b/%b",
                         c, obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid);
            end
            if (has_exp) begin
                tests_run++;
                if (obs_data !== exp_item.data || obs_plane !== exp_item.plane ||
                    obs_first !== exp_item.first || obs_last !== exp_item.last) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_plane c%0d: data_lo=%h plane=%0d f=%b l=%b, want %h/%0d/%b/%b",
                             c, obs_data[63:0], obs_plane, obs_first, obs_last,
                             exp_item.data[63:0], exp_item.plane, exp_item.first, exp_item.last);
                end
            end
        end
        tests_run++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_drain: %0d planes outstanding, out_valid=%b, want 0/0", sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        @(negedge clk);
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
